// File: rtl/toy_lsu_mem_arb.sv
// LSU memory request arbiter: load priority with store anti-starvation,
// outstanding-load credit limit and a single registered output slot.
module toy_lsu_mem_arb #(
    parameter int unsigned PLD_WIDTH          = 128,
    parameter int unsigned LD_OUTSTANDING_MAX = 8,
    parameter int unsigned STARVE_MAX         = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  ld_req_vld,
    output logic                                  ld_req_rdy,
    input  logic [PLD_WIDTH-1:0]                  ld_req_pld,
    input  logic                                  st_req_vld,
    output logic                                  st_req_rdy,
    input  logic [PLD_WIDTH-1:0]                  st_req_pld,
    output logic                                  m_req_vld,
    input  logic                                  m_req_rdy,
    output logic [PLD_WIDTH-1:0]                  m_req_pld,
    output logic                                  m_req_is_ld,
    input  logic                                  mem_ack_vld,
    input  logic                                  mem_ack_rdy,
    input  logic                                  mem_ack_is_ld,
    input  logic                                  cancel_en,
    output logic [$clog2(LD_OUTSTANDING_MAX):0]   ld_outstanding,
    output logic [$clog2(STARVE_MAX):0]           st_starve_cnt
);

    localparam int unsigned LDW = $clog2(LD_OUTSTANDING_MAX) + 1;
    localparam int unsigned SCW = $clog2(STARVE_MAX) + 1;
    localparam logic [LDW-1:0] LD_MAX = LDW'(LD_OUTSTANDING_MAX);
    localparam logic [SCW-1:0] ST_MAX = SCW'(STARVE_MAX);

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_LD   = 2'd1,
        GNT_ST   = 2'd2
    } gnt_e;

    logic                 r_vld;
    logic [PLD_WIDTH-1:0] r_pld;
    logic                 r_is_ld;
    logic [LDW-1:0]       r_ld_cnt;
    logic [SCW-1:0]       r_starve;

    logic                 w_slot_free;
    logic                 w_ld_elig;
    logic                 w_starved;
    logic                 w_ack_ld;
    gnt_e                 w_gnt;
    logic [LDW-1:0]       w_ld_cnt_nxt;
    logic [SCW-1:0]       w_starve_nxt;

    assign w_slot_free = !r_vld || m_req_rdy;
    // Eligibility uses the registered credit count only; a same-cycle ack
    // does not bypass into the grant decision.
    assign w_ld_elig   = ld_req_vld && !cancel_en && (r_ld_cnt < LD_MAX);
    assign w_starved   = (r_starve >= ST_MAX);
    assign w_ack_ld    = mem_ack_vld && mem_ack_rdy && mem_ack_is_ld;

    always_comb begin
        w_gnt = GNT_NONE;
        if (w_slot_free) begin
            if (w_starved && st_req_vld) begin
                w_gnt = GNT_ST;
            end else if (w_ld_elig) begin
                w_gnt = GNT_LD;
            end else if (st_req_vld) begin
                w_gnt = GNT_ST;
            end
        end
    end

    assign ld_req_rdy = (w_gnt == GNT_LD);
    assign st_req_rdy = (w_gnt == GNT_ST);

    always_comb begin
        w_ld_cnt_nxt = r_ld_cnt;
        case ({w_gnt == GNT_LD, w_ack_ld})
            2'b10:   w_ld_cnt_nxt = r_ld_cnt + LDW'(1);
            2'b01:   if (r_ld_cnt != '0) w_ld_cnt_nxt = r_ld_cnt - LDW'(1);
            default: w_ld_cnt_nxt = r_ld_cnt;
        endcase
    end

    always_comb begin
        w_starve_nxt = r_starve;
        if (w_gnt == GNT_ST) begin
            w_starve_nxt = '0;
        end else if ((w_gnt == GNT_LD) && st_req_vld && (r_starve < ST_MAX)) begin
            w_starve_nxt = r_starve + SCW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld   <= 1'b0;
            r_pld   <= '0;
            r_is_ld <= 1'b0;
        end else if (w_slot_free) begin
            r_vld <= (w_gnt != GNT_NONE);
            if (w_gnt == GNT_LD) begin
                r_pld   <= ld_req_pld;
                r_is_ld <= 1'b1;
            end else if (w_gnt == GNT_ST) begin
                r_pld   <= st_req_pld;
                r_is_ld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_cnt <= '0;
            r_starve <= '0;
        end else begin
            r_ld_cnt <= w_ld_cnt_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    assign m_req_vld      = r_vld;
    assign m_req_pld      = r_pld;
    assign m_req_is_ld    = r_is_ld;
    assign ld_outstanding = r_ld_cnt;
    assign st_starve_cnt  = r_starve;

`ifndef SYNTHESIS
    // A load ack with no load outstanding is a protocol error upstream.
    a_no_ack_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_ack_ld && (r_ld_cnt == '0)));
`endif

endmodule

// File: doc/toy_lsu_mem_arb.md
Name: toy_lsu_mem_arb

Overview:
- Arbitrates the load-queue and store-queue memory request channels onto the single LSU memory request port.
- Replaces a fixed-priority arbiter with three additions: load priority with store anti-starvation, an outstanding-load credit limit, and a registered output stage.
- Sits between the LSU queues and the bus request port. It also observes the memory ack channel to return load credits.

Parameters:
- PLD_WIDTH, 128, width of the opaque request payload (address/data/strobe/opcode/sideband), passed through unmodified.
- LD_OUTSTANDING_MAX, 8, maximum loads issued but not yet acked.
- STARVE_MAX, 4, number of consecutive store losses that forces one store grant.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ld_req_vld  in  1  load-queue request valid.
- ld_req_rdy  out  1  load request accepted this cycle.
- ld_req_pld  in  PLD_WIDTH  load request payload.
- st_req_vld  in  1  store-queue request valid.
- st_req_rdy  out  1  store request accepted this cycle.
- st_req_pld  in  PLD_WIDTH  store request payload.
- m_req_vld  out  1  memory request valid (registered).
- m_req_rdy  in  1  memory port ready.
- m_req_pld  out  PLD_WIDTH  granted payload (registered).
- m_req_is_ld  out  1  1 = held request is a load.
- mem_ack_vld  in  1  memory ack valid.
- mem_ack_rdy  in  1  ack consumer ready; an ack fires when vld && rdy.
- mem_ack_is_ld  in  1  ack belongs to a load.
- cancel_en  in  1  pipeline flush active.
- ld_outstanding  out  $clog2(LD_OUTSTANDING_MAX)+1  current outstanding-load count.
- st_starve_cnt  out  $clog2(STARVE_MAX)+1  current store starvation count.

Behaviour:
- Reset values: m_req_vld=0, m_req_pld=0, m_req_is_ld=0, ld_outstanding=0, st_starve_cnt=0. ld_req_rdy and st_req_rdy are combinational and therefore 0 while the output stage is full and stalled.
- Output stage is one register slot. slot_free = !m_req_vld || m_req_rdy. A grant happens only when slot_free.
- Latency: a request granted in cycle N appears on m_req_vld in cycle N+1. Back-to-back grants sustain one request per cycle.
- Handshake stability: while m_req_vld && !m_req_rdy, m_req_pld and m_req_is_ld hold stable. cancel_en never drops or alters a held request.
- Load eligibility: ld_elig = ld_req_vld && !cancel_en && ld_outstanding < LD_OUTSTANDING_MAX.
  - Uses the registered count only. An ack firing in the same cycle does not unblock the load (no bypass).
- Store eligibility: st_elig = st_req_vld. Stores are not blocked by cancel_en.
- Grant rule, evaluated when slot_free:
  - If st_starve_cnt >= STARVE_MAX and st_elig: grant store.
  - Else if ld_elig: grant load.
  - Else if st_elig: grant store.
  - Else: no grant; m_req_vld becomes 0 next cycle if the slot drains.
- Exactly one of ld_req_rdy and st_req_rdy is high per grant. They are never both high.
- st_starve_cnt:
  - Reset to 0 on a store grant.
  - Incremented, saturating at STARVE_MAX, when st_req_vld is high and a load is granted.
  - Otherwise held.
- ld_outstanding: +1 on a load grant; -1 on an ack fire with mem_ack_is_ld=1. If both happen in the same cycle, the count is unchanged.
- Boundary conditions:
  - Count == LD_OUTSTANDING_MAX: loads are stalled and stores may proceed.
  - A load ack while the count is 0 is a protocol error. The count stays 0, and simulation asserts.
- Reset mid-operation: all state clears immediately (asynchronous). Any in-flight request is lost; the bus side is reset concurrently.

Test Plan:
- Load only, m_req_rdy=1, 10 load requests, LD_OUTSTANDING_MAX=8, no acks -> 8 grants on consecutive cycles, m_req_vld 1 cycle after each grant, ld_req_rdy=0 from the 9th request, ld_outstanding=8.
- From that state, one load ack fires -> ld_outstanding=7 next cycle and the 9th load is granted that cycle, not in the ack cycle. Simultaneous grant+ack keeps the count at 7.
- ld and st both valid continuously, STARVE_MAX=4, no ack limit -> grant pattern L,L,L,L,S repeating; st_starve_cnt sequence 1,2,3,4,0.
- m_req_rdy=0 for 5 cycles with a load held -> m_req_pld stable, no rdy asserted to either queue. When rdy rises, the next grant appears the following cycle with no bubble.
- cancel_en=1 with both valid -> only stores are granted, and a held load stays on m_req_vld until accepted. When cancel_en drops, loads resume next cycle.
- Async reset asserted with m_req_vld=1 and ld_outstanding=5 -> all outputs are 0 immediately. After reset release, the first grant occurs 1 cycle after a request.
